// File: rtl/seq_pattern_detector_if.sv
// Serial bit stream in, match tick and window status out.
// Carries hit_count only when SEQ_PATTERN_DETECTOR_HIT_COUNT_EN is defined.
interface seq_pattern_detector_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             tick;
    logic [PAT_W-1:0] window;
    logic             primed;
`ifdef SEQ_PATTERN_DETECTOR_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_count;

    modport master (
        output bit_in, bit_valid,
        input  tick, window, primed, hit_count
    );
    modport slave (
        input  bit_in, bit_valid,
        output tick, window, primed, hit_count
    );
`else
    modport master (
        output bit_in, bit_valid,
        input  tick, window, primed
    );
    modport slave (
        input  bit_in, bit_valid,
        output tick, window, primed
    );
`endif
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector, overlap or non-overlap matching by parameter.
// Optional saturating hit counter: SEQ_PATTERN_DETECTOR_HIT_COUNT_EN.
module seq_pattern_detector #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_pattern_detector_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    typedef enum logic {
        S_FILL,
        S_ARMED
    } state_e;

    state_e            state_q, state_d;
    logic [PAT_W-1:0]  window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W-1:0] fill_inc;
    logic              tick_q, tick_d;
    logic              match;

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        fill_d   = fill_q;
        fill_inc = fill_q;
        tick_d   = 1'b0;
        match    = 1'b0;
        if (bus.bit_valid) begin
            window_d = {window_q[PAT_W-2:0], bus.bit_in};
            fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
            fill_d   = fill_inc;
            match    = (fill_inc == FULL) && (window_d == PATTERN);
            tick_d   = match;
            case (state_q)
                S_FILL:  if (fill_inc == FULL) state_d = S_ARMED;
                S_ARMED: state_d = S_ARMED;
                default: state_d = S_FILL;
            endcase
            // Non-overlap: keep the window but demand PAT_W fresh bits.
            if (match && !OVERLAP) begin
                fill_d  = '0;
                state_d = S_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FILL;
            window_q <= '0;
            fill_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.tick   = tick_q;
    assign bus.window = window_q;
    assign bus.primed = (state_q == S_ARMED);

`ifdef SEQ_PATTERN_DETECTOR_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    always_comb begin
        hit_count_d = hit_count_q;
        if (tick_d && (hit_count_q != {CNT_W{1'b1}}))
            hit_count_d = hit_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) hit_count_q <= '0;
        else        hit_count_q <= hit_count_d;
    end

    assign bus.hit_count = hit_count_q;
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: 1011 overlap / non-overlap and 111 overlap detectors.
// Hit-counter checks run when SEQ_PATTERN_DETECTOR_HIT_COUNT_EN is defined.
module tb_seq_pattern_detector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(16)) ov_if ();
  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(16)) no_if ();
  seq_pattern_detector_if #(.PAT_W(3), .CNT_W(2))  t3_if ();

  seq_pattern_detector #(
    .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(16)
  ) dut_ov (.clk(clk), .reset(reset), .bus(ov_if.slave));

  seq_pattern_detector #(
    .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(16)
  ) dut_no (.clk(clk), .reset(reset), .bus(no_if.slave));

  seq_pattern_detector #(
    .PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(2)
  ) dut_t3 (.clk(clk), .reset(reset), .bus(t3_if.slave));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // which: 0=ov 1=no 2=t3; others idle with random bit_in
  task automatic drive(input int which, input logic v,
                       input logic b);
    ov_if.bit_valid = (which == 0) && v;
    no_if.bit_valid = (which == 1) && v;
    t3_if.bit_valid = (which == 2) && v;
    ov_if.bit_in = (which == 0) ? b : 1'($urandom);
    no_if.bit_in = (which == 1) ? b : 1'($urandom);
    t3_if.bit_in = (which == 2) ? b : 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(-1, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  logic [7:0] bits;
  logic [7:0] tk;
  logic [7:0] pr;
  logic [1:0] hc [8];

  initial begin
    ov_if.bit_valid = 1'b0;
    no_if.bit_valid = 1'b0;
    t3_if.bit_valid = 1'b0;
    ov_if.bit_in = 1'b0;
    no_if.bit_in = 1'b0;
    t3_if.bit_in = 1'b0;
    drive(-1, 1'b0, 1'b0);
    drive(-1, 1'b0, 1'b0);
    check("rst_tick", 32'(ov_if.tick), 32'd0);
    check("rst_window", 32'(ov_if.window), 32'd0);
    check("rst_primed", 32'(ov_if.primed), 32'd0);
    reset = 1'b1;

    // 1: overlap, 1011011 -> ticks after bits 4 and 7
    bits = 8'b1011_0110;
    tk   = 8'b0001_0010;
    for (int i = 0; i < 7; i++) begin
      drive(0, 1'b1, bits[7-i]);
      check($sformatf("ov_tick%0d", i + 1),
            32'(ov_if.tick), 32'(tk[7-i]));
    end
    check("ov_window7", 32'(ov_if.window), 32'hB);
    check("ov_primed7", 32'(ov_if.primed), 32'd1);
    drive(-1, 1'b0, 1'b0);
    check("ov_tick_idle", 32'(ov_if.tick), 32'd0);
    check("ov_window_idle", 32'(ov_if.window), 32'hB);

    // 2: non-overlap, 1011011 + 0
    do_reset();
    bits = 8'b1011_0110;
    tk   = 8'b0001_0000;
    pr   = 8'b0000_0001;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, bits[7-i]);
      check($sformatf("no_tick%0d", i + 1),
            32'(no_if.tick), 32'(tk[7-i]));
      check($sformatf("no_primed%0d", i + 1),
            32'(no_if.primed), 32'(pr[7-i]));
    end
    check("no_window8", 32'(no_if.window), 32'h6);

    // 3: valid every 3rd cycle, random bit_in otherwise
    do_reset();
    bits = 8'b1011_0000;
    tk   = 8'b0001_0000;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, bits[7-i]);
      check($sformatf("sp_tick%0d", i + 1),
            32'(ov_if.tick), 32'(tk[7-i]));
      for (int j = 0; j < 2; j++) begin
        ov_if.bit_valid = 1'b0;
        ov_if.bit_in = 1'($urandom);
        @(posedge clk);
        #1;
        check($sformatf("sp_idle_tick%0d_%0d", i + 1, j),
              32'(ov_if.tick), 32'd0);
      end
      check($sformatf("sp_window%0d", i + 1),
            32'(ov_if.window), 32'(bits[7:4] >> (3 - i)));
    end

    // 4: reset mid-stream drops all history
    do_reset();
    drive(0, 1'b1, 1'b1);
    drive(0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1);
    reset = 1'b0;
    drive(0, 1'b1, 1'b1);
    reset = 1'b1;
    check("mr_window_rst", 32'(ov_if.window), 32'd0);
    drive(0, 1'b1, 1'b1);
    check("mr_tick", 32'(ov_if.tick), 32'd0);
    check("mr_window", 32'(ov_if.window), 32'h1);
    check("mr_primed", 32'(ov_if.primed), 32'd0);
    drive(0, 1'b1, 1'b0);
    check("mr_tick2", 32'(ov_if.tick), 32'd0);
    drive(0, 1'b1, 1'b1);
    check("mr_tick3", 32'(ov_if.tick), 32'd0);
    drive(0, 1'b1, 1'b1);
    check("mr_tick4", 32'(ov_if.tick), 32'd1);
    check("mr_window4", 32'(ov_if.window), 32'hB);

    // 5/6: 111 overlap, eight ones -> six ticks; counter saturates at 3
    do_reset();
    tk = 8'b0011_1111;
    hc = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 8; i++) begin
      drive(2, 1'b1, 1'b1);
      check($sformatf("t3_tick%0d", i + 1),
            32'(t3_if.tick), 32'(tk[7-i]));
`ifdef SEQ_PATTERN_DETECTOR_HIT_COUNT_EN
      check($sformatf("t3_hits%0d", i + 1),
            32'(t3_if.hit_count), 32'(hc[i]));
`endif
    end
    drive(-1, 1'b0, 1'b0);
    check("t3_tick_idle", 32'(t3_if.tick), 32'd0);
`ifdef SEQ_PATTERN_DETECTOR_HIT_COUNT_EN
    check("t3_hits_idle", 32'(t3_if.hit_count), 32'd3);
    do_reset();
    check("t3_hits_rst", 32'(t3_if.hit_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
